relu_maxpool2x2: RTL and testbench
==================================

# relu_maxpool2x2

Streaming 2x2/stride-2 max-pooling stage with optional ReLU. It sits directly downstream of the MAC/convolution datapath and consumes one 16-bit convolution result per accepted beat in raster order. It emits one pooled 16-bit value per 2x2 window to the next layer or to the feature-map store. A half-width row buffer holds the horizontal maxima of each even row until the matching odd row arrives.

## Interface
Parameters:
- IMG_W, 26: input feature-map width in pixels (≥2).
- IMG_H, 26: input feature-map height in rows (≥2).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  16  MAC result, two's-complement signed.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  16  pooled value, signed.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  qualifies the final pooled value of a frame.

## Operation
- Beat accepted when in_valid && in_ready. Only accepted beats advance state.
- Counters:
  - col runs 0..IMG_W-1 and wraps to 0, incrementing row.
  - row runs 0..IMG_H-1 and wraps to 0, which starts the next frame.
- All comparisons are signed 16-bit. Equal values leave the result unchanged.
- Even col (col[0]=0): hmax <= in_data.
- Odd col, even row: rowbuf[col>>1] <= max(hmax, in_data). No output.
- Odd col, odd row: out_data <= max(rowbuf[col>>1], hmax, in_data) and out_valid <= 1.
  - out_last <= (row==IMG_H-1 or row==IMG_H-2 with IMG_H odd) && (col is the last odd column).
- Odd IMG_W: the trailing column is accepted and discarded; it does not update hmax or rowbuf.
- Odd IMG_H: the trailing row is accepted and discarded; no output is produced for it.
- rowbuf has IMG_W/2 entries of 16 bits and is not reset. Each even row fully overwrites the entries used by the following odd row.
- Output register:
  - Cleared (out_valid <= 0) when out_valid && out_ready and no new result is loaded in the same cycle.
  - A simultaneous accept and load keeps out_valid=1 with the new data.
- in_ready = !out_valid || out_ready, combinational. A held output stalls the input stream.
- No overflow is possible; values pass through unchanged apart from the ReLU option.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, col=0, row=0, hmax=0. in_ready=1 during and after reset.
- Latency: out_valid rises in the cycle after the bottom-right pixel of a window is accepted.
- Throughput: one input beat per cycle. Output rate is 1 per 2 input beats on odd rows.
- out_data and out_last are held stable while out_valid && !out_ready.
- rst mid-frame: the partial frame is discarded, any pending output is dropped, and the next accepted beat is pixel (0,0).
- in_valid may drop at any beat without effect on state.

## Configuration
- RELU_EN defined: every loaded output is max(pool, 0); negative results become 0x0000.
- RELU_EN undefined: the raw signed maximum is output.
- Control timing is identical in both builds.

## Test plan
- IMG_W=4, IMG_H=4, inputs 1..16 raster, out_ready=1:
  - Expect outputs 6, 8, 14, 16 in order.
  - out_last=1 only with 16.
  - Each output appears one cycle after inputs 6, 8, 14, 16 are accepted.
- Signed compare: a window {0x8000, 0x7FFF, 0xFFFF, 0x0001} produces 0x7FFF.
  - Repeat with all four values = 0xFFFB: output 0x0000 with RELU_EN, 0xFFFB without.
- Backpressure: hold out_ready=0 when output 6 appears.
  - in_ready=0 and out_data stays 6 until out_ready=1.
  - No input is lost; the remaining outputs are 8, 14, 16.
- Odd dims, IMG_W=5, IMG_H=5, inputs 1..25:
  - Expect outputs 7, 9, 17, 19; out_last with 19.
  - Column 4 and row 4 are consumed without output, and the next frame restarts correctly.
- Reset mid-frame: assert rst after 6 beats of the 4x4 frame, then stream a fresh 1..16.
  - Exactly 6, 8, 14, 16 are produced.
  - Outputs are 0 during reset.
- Random in_valid gaps with random out_ready over 3 back-to-back frames match a reference model bit-exactly, with out_last once per frame.

Source files
------------

// File: rtl/relu_maxpool2x2.sv
// Streaming 2x2 / stride-2 signed max-pool over a raster feature map, with a half-width row buffer.
// Optional build macro RELU_EN clamps every pooled result at zero.
module relu_maxpool2x2 #(
  parameter int IMG_W = 26,
  parameter int IMG_H = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  localparam int CW           = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW           = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BD           = IMG_W / 2;
  localparam int BW           = (BD > 1) ? $clog2(BD) : 1;
  localparam int LAST_ODD_COL = (IMG_W / 2) * 2 - 1;
  localparam int LAST_ODD_ROW = (IMG_H / 2) * 2 - 1;
  localparam bit ODD_W        = (IMG_W % 2) != 0;
  localparam bit ODD_H        = (IMG_H % 2) != 0;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [15:0]   hmax;
  logic [15:0]   rowbuf [BD];

  logic          accept;
  logic          col_wrap;
  logic          row_wrap;
  logic          keep;
  logic          ld_h;
  logic          wr_buf;
  logic          ld_out;
  logic [BW-1:0] idx;
  logic [15:0]   buf_rd;
  logic [15:0]   h_pair;
  logic [15:0]   pool;
  logic [15:0]   result;
  logic          last_hit;

  function automatic logic [15:0] smax(input logic [15:0] a, input logic [15:0] b);
    return ($signed(b) > $signed(a)) ? b : a;
  endfunction

  // Handshake: a beat moves on any edge where valid && ready. in_ready is
  // combinational from the output register, so a stalled result holds the input.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign col_wrap = (col == CW'(IMG_W - 1));
  assign row_wrap = (row == RW'(IMG_H - 1));

  // Trailing column/row of odd-sized maps is consumed but never pooled.
  always_comb begin
    keep   = accept && !(ODD_W && col_wrap) && !(ODD_H && row_wrap);
    ld_h   = keep && !col[0];
    wr_buf = keep && col[0] && !row[0];
    ld_out = keep && col[0] && row[0];
  end

  assign idx      = BW'(col >> 1);
  assign buf_rd   = rowbuf[idx];
  assign h_pair   = smax(hmax, in_data);
  assign pool     = smax(smax(buf_rd, hmax), in_data);
  assign last_hit = (row == RW'(LAST_ODD_ROW)) && (col == CW'(LAST_ODD_COL));

`ifdef RELU_EN
  assign result = pool[15] ? 16'h0000 : pool;
`else
  assign result = pool;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_wrap) begin
        col <= '0;
        row <= row_wrap ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hmax <= '0;
    end else if (ld_h) begin
      hmax <= in_data;
    end
  end

  // Not reset: every even row rewrites the entries its odd partner reads.
  always_ff @(posedge clk) begin
    if (!rst && wr_buf) begin
      rowbuf[idx] <= h_pair;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (ld_out) begin
      out_valid <= 1'b1;
      out_data  <= result;
      out_last  <= last_hit;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  a_out_hold : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)));

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Directed bench for relu_maxpool2x2: a 4x4 instance and a 5x5 instance,
// scoreboard queues of {last, data} and a final summary line.
module tb_relu_maxpool2x2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] in_data_a, out_data_a, in_data_b, out_data_b;
  logic in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a;
  logic in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b;

  relu_maxpool2x2 #(.IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a), .out_last(out_last_a)
  );

  relu_maxpool2x2 #(.IMG_W(5), .IMG_H(5)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_last(out_last_b)
  );

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q_a[$];
  logic [16:0] exp_q_b[$];
  int last_cnt_a = 0;
  bit rand_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- clock/reset + watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready_a = 1'($urandom_range(0, 1));
  end

  // ---------------- scoreboards ----------------
  logic hold_a = 1'b0, hold_b = 1'b0;
  logic [16:0] held_a, held_b, e_a, e_b;

  always @(negedge clk) begin
    if (rst) hold_a = 1'b0;
    else begin
      if (hold_a && out_valid_a) check("a_hold", 32'({out_last_a, out_data_a}), 32'(held_a));
      if (out_valid_a && out_ready_a) begin
        if (exp_q_a.size() == 0) check("a_extra_out", 32'(out_valid_a), 32'd0);
        else begin
          e_a = exp_q_a.pop_front();
          check("a_out", 32'({out_last_a, out_data_a}), 32'(e_a));
          if (out_last_a) last_cnt_a++;
        end
        hold_a = 1'b0;
      end else begin
        hold_a = out_valid_a;
        held_a = {out_last_a, out_data_a};
      end
    end
  end

  always @(negedge clk) begin
    if (rst) hold_b = 1'b0;
    else begin
      if (hold_b && out_valid_b) check("b_hold", 32'({out_last_b, out_data_b}), 32'(held_b));
      if (out_valid_b && out_ready_b) begin
        if (exp_q_b.size() == 0) check("b_extra_out", 32'(out_valid_b), 32'd0);
        else begin
          e_b = exp_q_b.pop_front();
          check("b_out", 32'({out_last_b, out_data_b}), 32'(e_b));
        end
        hold_b = 1'b0;
      end else begin
        hold_b = out_valid_b;
        held_b = {out_last_b, out_data_b};
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 right after the beat is accepted.
  task automatic send(input int sel, input logic [15:0] d, input int gap);
    int n;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    if (sel == 0) begin in_data_a = d; in_valid_a = 1'b1; end
    else begin in_data_b = d; in_valid_b = 1'b1; end
    n = 0;
    @(negedge clk);
    while (((sel == 0) ? in_ready_a : in_ready_b) == 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("in_ready_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    if (sel == 0) in_valid_a = 1'b0; else in_valid_b = 1'b0;
  endtask

  task automatic wait_drain(input int sel);
    int n;
    n = 0;
    while (((sel == 0) ? exp_q_a.size() : exp_q_b.size()) > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check((sel == 0) ? "a_drain" : "b_drain",
          32'((sel == 0) ? exp_q_a.size() : exp_q_b.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_pool(input logic [15:0] p0, input logic [15:0] p1,
                                           input logic [15:0] p2, input logic [15:0] p3);
    logic signed [15:0] m;
    m = $signed(p0);
    if ($signed(p1) > m) m = $signed(p1);
    if ($signed(p2) > m) m = $signed(p2);
    if ($signed(p3) > m) m = $signed(p3);
`ifdef RELU_EN
    if (m < 0) m = 0;
`endif
    return m;
  endfunction

  // ---------------- stimulus ----------------
  logic [15:0] sv [16];
  logic [15:0] rf [3][16];
  bit lastb;

  initial begin
    rst = 1'b1;
    in_data_a = '0; in_valid_a = 1'b0; out_ready_a = 1'b1;
    in_data_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_valid", 32'(out_valid_a), 32'd0);
    check("rst_a_data",  32'(out_data_a),  32'd0);
    check("rst_a_last",  32'(out_last_a),  32'd0);
    check("rst_a_ready", 32'(in_ready_a),  32'd1);
    check("rst_b_valid", 32'(out_valid_b), 32'd0);
    check("rst_b_ready", 32'(in_ready_b),  32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // 4x4 ramp, full-rate: outputs 6,8,14,16, one cycle after the window closes
    exp_q_a.push_back({1'b0, 16'd6});  exp_q_a.push_back({1'b0, 16'd8});
    exp_q_a.push_back({1'b0, 16'd14}); exp_q_a.push_back({1'b1, 16'd16});
    for (int k = 1; k <= 16; k++) begin
      send(0, 16'(k), 0);
      check("t1_latency", 32'(out_valid_a), 32'(k == 6 || k == 8 || k == 14 || k == 16));
    end
    wait_drain(0);

    // signed compare, negative windows and the ReLU clamp
    sv = '{16'h8000, 16'h7FFF, 16'hFFFB, 16'hFFFB,
           16'hFFFF, 16'h0001, 16'hFFFB, 16'hFFFB,
           16'h0003, 16'hFFFE, 16'h8000, 16'h8001,
           16'h0002, 16'h0004, 16'h8002, 16'h8000};
    exp_q_a.push_back({1'b0, 16'h7FFF});
`ifdef RELU_EN
    exp_q_a.push_back({1'b0, 16'h0000});
    exp_q_a.push_back({1'b0, 16'h0004});
    exp_q_a.push_back({1'b1, 16'h0000});
`else
    exp_q_a.push_back({1'b0, 16'hFFFB});
    exp_q_a.push_back({1'b0, 16'h0004});
    exp_q_a.push_back({1'b1, 16'h8002});
`endif
    for (int k = 0; k < 16; k++) send(0, sv[k], 0);
    wait_drain(0);

    // backpressure: output 6 held while the input stalls
    out_ready_a = 1'b0;
    exp_q_a.push_back({1'b0, 16'd6});  exp_q_a.push_back({1'b0, 16'd8});
    exp_q_a.push_back({1'b0, 16'd14}); exp_q_a.push_back({1'b1, 16'd16});
    fork
      for (int k = 1; k <= 16; k++) send(0, 16'(k), 0);
      begin
        int n;
        n = 0;
        while (!out_valid_a && n < 100) begin @(negedge clk); n++; end
        check("t3_valid_seen", 32'(out_valid_a), 32'd1);
        repeat (4) begin
          @(negedge clk);
          check("t3_in_ready", 32'(in_ready_a), 32'd0);
          check("t3_hold_data", 32'(out_data_a), 32'd6);
        end
        @(posedge clk); #1;
        out_ready_a = 1'b1;
      end
    join
    wait_drain(0);

    // 5x5 odd dims, two frames back to back
    for (int f = 0; f < 2; f++) begin
      exp_q_b.push_back({1'b0, 16'd7});  exp_q_b.push_back({1'b0, 16'd9});
      exp_q_b.push_back({1'b0, 16'd17}); exp_q_b.push_back({1'b1, 16'd19});
    end
    for (int f = 0; f < 2; f++) begin
      for (int k = 1; k <= 25; k++) begin
        send(1, 16'(k), 0);
        check("t4_latency", 32'(out_valid_b), 32'(k == 7 || k == 9 || k == 17 || k == 19));
      end
    end
    wait_drain(1);

    // reset mid-frame with a pending output
    out_ready_a = 1'b0;
    for (int k = 1; k <= 6; k++) send(0, 16'(k), 0);
    check("t5_pending", 32'(out_valid_a), 32'd1);
    rst = 1'b1;
    in_valid_a = 1'b1;
    in_data_a = 16'h7777;
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_rst_valid", 32'(out_valid_a), 32'd0);
    check("t5_rst_data",  32'(out_data_a),  32'd0);
    check("t5_rst_last",  32'(out_last_a),  32'd0);
    check("t5_rst_ready", 32'(in_ready_a),  32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid_a = 1'b0;
    out_ready_a = 1'b1;
    exp_q_a.push_back({1'b0, 16'd6});  exp_q_a.push_back({1'b0, 16'd8});
    exp_q_a.push_back({1'b0, 16'd14}); exp_q_a.push_back({1'b1, 16'd16});
    for (int k = 1; k <= 16; k++) send(0, 16'(k), 0);
    wait_drain(0);

    // three random frames with input gaps and random out_ready
    last_cnt_a = 0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 16; k++) rf[f][k] = 16'($urandom_range(0, 65535));
      for (int wr = 0; wr < 2; wr++) begin
        for (int wc = 0; wc < 2; wc++) begin
          lastb = (wr == 1) && (wc == 1);
          exp_q_a.push_back({lastb, ref_pool(rf[f][wr*8 + wc*2], rf[f][wr*8 + wc*2 + 1],
                                             rf[f][wr*8 + 4 + wc*2], rf[f][wr*8 + 4 + wc*2 + 1])});
        end
      end
    end
    rand_rdy = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 16; k++) send(0, rf[f][k], $urandom_range(0, 2));
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready_a = 1'b1;
    wait_drain(0);
    check("t6_last_count", 32'(last_cnt_a), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
